// File: rtl/dac_level_ctrl.sv
// Per-channel DAC level controller: less/more buttons nudge a selected channel's code,
// and a small sequencer pushes every changed channel to the DAC serial driver one write at a time.
module dac_level_ctrl #(
  parameter int          WIDTH = 12,
  parameter int          NCH   = 4,
  parameter int          STEP  = 400,
  parameter int unsigned INIT  = 'h03F
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic             less,
  input  logic             more,
  input  logic [3:0]       chsel,
  output logic [WIDTH-1:0] data,
  output logic [3:0]       address,
  output logic [3:0]       command,
  output logic             dactrig,
  input  logic             dacdone,
  output logic             busy
);

  localparam logic [WIDTH-1:0] INIT_C   = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] FULL_C   = '1;
  localparam logic [WIDTH:0]   STEP_C   = (WIDTH+1)'(STEP);
  localparam bit               STEP_BIG = (64'(STEP) >= (64'd1 << WIDTH));
  localparam logic [4:0]       NCH_C    = 5'(NCH);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lvl_q [NCH];
  logic [WIDTH-1:0] lvl_d [NCH];
  logic [NCH-1:0]   dirty_q, dirty_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       addr_q, addr_d;
  logic             lessPrev_q, morePrev_q;

  logic             lessEdge, moreEdge, chselOk, adjust;
  logic [WIDTH-1:0] selLvl, newLvl;
  logic [WIDTH:0]   sumUp;
  logic [NCH-1:0]   pickMask;
  logic [3:0]       pickIdx;
  logic [WIDTH-1:0] pickLvl;
  logic             found;

  assign lessEdge = less & ~lessPrev_q;
  assign moreEdge = more & ~morePrev_q;
  assign chselOk  = {1'b0, chsel} < NCH_C;
  assign adjust   = chselOk & (lessEdge ^ moreEdge);

  always_comb begin
    selLvl = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chsel == 4'(i)) selLvl = lvl_q[i];
    end
  end

  // Saturating step; the up-sum carries one extra bit so overflow is visible instead of wrapping.
  always_comb begin
    sumUp  = {1'b0, selLvl} + STEP_C;
    newLvl = selLvl;
    if (moreEdge) begin
      if (STEP_BIG || sumUp[WIDTH]) newLvl = FULL_C;
      else                          newLvl = sumUp[WIDTH-1:0];
    end else begin
      if (STEP_BIG || ({1'b0, selLvl} < STEP_C)) newLvl = '0;
      else                                       newLvl = selLvl - STEP_C[WIDTH-1:0];
    end
  end

  // Lowest-index dirty channel, isolated as the lowest set bit of the flag vector.
  always_comb begin
    pickMask = dirty_q & (-dirty_q);
    found    = |dirty_q;
    pickIdx  = '0;
    pickLvl  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pickMask[i]) begin
        pickIdx = 4'(i);
        pickLvl = lvl_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = TRIG;
      TRIG:    state_d = WAIT;
      WAIT:    if (dacdone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fresh adjustment re-sets its dirty flag after the pick clears it, so a channel
  // touched while being latched is queued again.
  always_comb begin
    data_d  = data_q;
    addr_d  = addr_q;
    dirty_d = dirty_q;
    lvl_d   = lvl_q;
    if (state_q == IDLE && found) begin
      data_d  = pickLvl;
      addr_d  = pickIdx;
      dirty_d = dirty_q & ~pickMask;
    end
    if (adjust) begin
      for (int i = 0; i < NCH; i++) begin
        if (chsel == 4'(i)) begin
          lvl_d[i]   = newLvl;
          dirty_d[i] = 1'b1;
        end
      end
    end
  end

  // Edge detectors load the live inputs during reset so a button held across release is not an edge.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q    <= IDLE;
      dirty_q    <= '1;
      data_q     <= INIT_C;
      addr_q     <= '0;
      lessPrev_q <= less;
      morePrev_q <= more;
      for (int i = 0; i < NCH; i++) lvl_q[i] <= INIT_C;
    end else begin
      state_q    <= state_d;
      dirty_q    <= dirty_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      lessPrev_q <= less;
      morePrev_q <= more;
      for (int i = 0; i < NCH; i++) lvl_q[i] <= lvl_d[i];
    end
  end

  always_comb begin
    dactrig = (state_q == TRIG);
    busy    = (state_q != IDLE);
  end

  assign data    = data_q;
  assign address = addr_q;
  assign command = 4'b0011;

endmodule

// File: tb/tb_dac_level_ctrl.sv
// Bench for dac_level_ctrl: directed scenarios plus a long randomized run, all outputs
// compared each cycle against an arithmetic model of levels, dirty flags and write sequencing.
module tb_dac_level_ctrl;

  localparam int WIDTH = 12;
  localparam int NCH   = 4;
  localparam int STEP  = 400;
  localparam int INIT  = 'h03F;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             CLK50MHZ = 1'b0;
  logic             RST, less, more, dacdone;
  logic [3:0]       chsel;
  logic [WIDTH-1:0] data;
  logic [3:0]       address, command;
  logic             dactrig, busy;

  dac_level_ctrl #(.WIDTH(WIDTH), .NCH(NCH), .STEP(STEP), .INIT(INIT)) dut (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .less(less), .more(more), .chsel(chsel),
    .data(data), .address(address), .command(command), .dactrig(dactrig),
    .dacdone(dacdone), .busy(busy)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  int checks = 0;
  int errors = 0;

  int mLvl [NCH];
  bit mDirty [NCH];
  int mPhase;
  int mData, mAddr;
  bit mPrevLess, mPrevMore;

  int logAddr [$];
  int logData [$];
  int doneCnt   = 0;
  int doneDelay = 5;
  bit randDelay = 0;
  bit spurious  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Model: phase 0 = idle, 1 = trigger cycle, 2 = waiting on the driver.
  task automatic modelStep();
    bit le, me;
    int k;
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        mLvl[i]   = INIT;
        mDirty[i] = 1'b1;
      end
      mPhase = 0;
      mData  = INIT;
      mAddr  = 0;
    end else begin
      le = less && !mPrevLess;
      me = more && !mPrevMore;
      case (mPhase)
        0: begin
          k = -1;
          for (int i = NCH - 1; i >= 0; i--) if (mDirty[i]) k = i;
          if (k >= 0) begin
            mData     = mLvl[k];
            mAddr     = k;
            mDirty[k] = 1'b0;
            mPhase    = 1;
          end
        end
        1: mPhase = 2;
        default: if (dacdone) mPhase = 0;
      endcase
      if ((le != me) && (int'(chsel) < NCH)) begin
        if (me) mLvl[chsel] = (mLvl[chsel] + STEP > MAXV) ? MAXV : mLvl[chsel] + STEP;
        else    mLvl[chsel] = (mLvl[chsel] < STEP) ? 0 : mLvl[chsel] - STEP;
        mDirty[chsel] = 1'b1;
      end
    end
    mPrevLess = less;
    mPrevMore = more;
  endtask

  task automatic applyStimulus(input bit r, input bit l, input bit m, input logic [3:0] ch);
    RST   = r;
    less  = l;
    more  = m;
    chsel = ch;
    if (r) doneCnt = 0;
    dacdone = (doneCnt == 1) || (spurious && doneCnt == 0 && $urandom_range(0, 7) == 0);
    @(posedge CLK50MHZ);
    modelStep();
    #1;
    checkOutput("dactrig", dactrig, mPhase == 1);
    checkOutput("busy", busy, mPhase != 0);
    checkOutput("data", data, mData);
    checkOutput("address", address, mAddr);
    checkOutput("command", command, 4'b0011);
    if (doneCnt > 0) doneCnt--;
    if (dactrig === 1'b1) begin
      logAddr.push_back(int'(address));
      logData.push_back(int'(data));
      doneCnt = doneDelay;
      if (randDelay) doneDelay = $urandom_range(1, 6);
    end
  endtask

  task automatic pulse(input bit l, input bit m, input logic [3:0] ch, input int gap);
    applyStimulus(0, l, m, ch);
    repeat (gap) applyStimulus(0, 0, 0, ch);
  endtask

  task automatic checkLog(input string tag, input int idx, input int expAddr, input int expData);
    if (idx >= logAddr.size()) begin
      checkOutput({tag, "_missing"}, logAddr.size(), idx + 1);
    end else begin
      checkOutput({tag, "_addr"}, logAddr[idx], expAddr);
      checkOutput({tag, "_data"}, logData[idx], expData);
    end
  endtask

  initial begin
    int n, found;
    bit rl, rm;

    // Reset behaviour and the initial flush of all channels
    repeat (3) applyStimulus(1, 0, 0, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_data", data, INIT);
    logAddr.delete();
    logData.delete();
    repeat (40) applyStimulus(0, 0, 0, 0);
    checkOutput("flush_count", logAddr.size(), 4);
    for (int i = 0; i < 4; i++) checkLog("flush", i, i, 'h03F);
    checkOutput("flush_idle", busy, 0);

    // Three increments on channel 2
    logAddr.delete();
    logData.delete();
    repeat (3) pulse(0, 1, 4'd2, 12);
    checkOutput("ch2_count", logAddr.size(), 3);
    checkLog("ch2_w0", 0, 2, 'h1CF);
    checkLog("ch2_w1", 1, 2, 'h35F);
    checkLog("ch2_w2", 2, 2, 'h4EF);

    // Held button counts once, then walk up into saturation
    logAddr.delete();
    logData.delete();
    repeat (20) applyStimulus(0, 0, 1, 4'd1);
    repeat (10) applyStimulus(0, 0, 0, 4'd1);
    checkOutput("hold_count", logAddr.size(), 1);
    checkLog("hold", 0, 1, 'h1CF);
    repeat (11) pulse(0, 1, 4'd1, 12);
    checkOutput("sat_count", logAddr.size(), 12);
    checkLog("sat", 11, 1, 'hFFF);
    pulse(0, 1, 4'd1, 12);
    checkLog("sat_again", 12, 1, 'hFFF);

    // Decrement floors at zero; simultaneous edges and out-of-range channels do nothing
    logAddr.delete();
    logData.delete();
    pulse(1, 0, 4'd0, 12);
    checkLog("floor", 0, 0, 0);
    pulse(1, 1, 4'd0, 15);
    pulse(0, 1, 4'd9, 15);
    checkOutput("ignored_count", logAddr.size(), 1);

    // Adjust channel 3 while its write is in flight
    logAddr.delete();
    logData.delete();
    pulse(0, 1, 4'd3, 3);
    checkOutput("inflight_busy", busy, 1);
    pulse(0, 1, 4'd3, 20);
    checkOutput("inflight_count", logAddr.size(), 2);
    checkLog("inflight_w0", 0, 3, 'h1CF);
    checkLog("inflight_w1", 1, 3, 'h35F);

    // Reset during the wait of address 1 aborts and restarts the full flush
    repeat (2) applyStimulus(1, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (busy === 1'b1 && dactrig === 1'b0 && address === 4'd1) found = 1;
    end
    checkOutput("reach_wait_a1", found, 1);
    repeat (2) applyStimulus(1, 0, 0, 0);
    checkOutput("abort_trig", dactrig, 0);
    logAddr.delete();
    logData.delete();
    repeat (40) applyStimulus(0, 0, 0, 0);
    checkOutput("reflush_count", logAddr.size(), 4);
    for (int i = 0; i < 4; i++) checkLog("reflush", i, i, 'h03F);

    // Button held high through reset release gives no edge
    logAddr.delete();
    logData.delete();
    applyStimulus(1, 0, 1, 4'd0);
    repeat (40) applyStimulus(0, 0, 1, 4'd0);
    checkLog("held_rst", 0, 0, 'h03F);

    // Randomized run: random buttons, channels, driver latency, stray dacdone and resets
    randDelay = 1;
    spurious  = 1;
    rl = 0;
    rm = 0;
    for (int c = 0; c < 3000; c++) begin
      n = $urandom_range(0, 99);
      if (n < 12) rl = ~rl;
      else if (n < 26) rm = ~rm;
      applyStimulus($urandom_range(0, 299) == 0, rl, rm, 4'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_level_ctrl.md
DAC_LEVEL_CTRL -- requirements
Module: dac_level_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WIDTH, 12, DAC code width; NCH, 4, channel count (1..16); STEP, 400, code change per less/more press; INIT, 12'h03F, per-channel level after reset (truncated to WIDTH).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- CLK50MHZ  in  1  sole clock, rising edge
- RST  in  1  synchronous, active-high reset
- less  in  1  decrement request (level signal, may be held)
- more  in  1  increment request (level signal, may be held)
- chsel  in  4  channel adjusted by less/more; values >= NCH ignored
- data  out  WIDTH  DAC code for current write
- address  out  4  DAC channel address for current write
- command  out  4  DAC command, constant 4'b0011 (write and update)
- dactrig  out  1  one-cycle start pulse to DAC serial driver
- dacdone  in  1  one-cycle completion pulse from DAC serial driver
- busy  out  1  high while a write is outstanding
REQ-003 Clock is CLK50MHZ only; reset is RST, synchronous and active-high; no other clock or asynchronous reset SHALL exist.

Function
REQ-004 Block SHALL hold NCH level registers lvl[i] of WIDTH bits and NCH dirty flags.
REQ-005 less and more SHALL each be rising-edge detected with one registered stage; a held input SHALL produce exactly one adjustment.
REQ-006 On a more edge (no less edge same cycle), lvl[chsel] SHALL become lvl+STEP, saturating at 2^WIDTH-1; the comparison SHALL use a WIDTH+1-bit sum so no wrap-around occurs.
REQ-007 On a less edge (no more edge same cycle), lvl[chsel] SHALL become lvl-STEP, saturating at 0 when lvl < STEP.
REQ-008 Simultaneous less and more edges SHALL be ignored; edges with chsel >= NCH SHALL be ignored.
REQ-009 Any adjustment, including one that saturates to an unchanged value, SHALL set dirty[chsel].
REQ-010 FSM states SHALL be IDLE, TRIG, WAIT.
REQ-011 IDLE: if any dirty flag set, select lowest-index dirty channel k, latch data=lvl[k], address=k, clear dirty[k], go to TRIG; else stay.
REQ-012 TRIG: dactrig=1 for exactly this one cycle, go to WAIT.
REQ-013 WAIT: hold data/address/command stable; on dacdone go to IDLE; dacdone outside WAIT SHALL be ignored.
REQ-014 busy SHALL be 1 in TRIG and WAIT, 0 in IDLE.
REQ-015 Adjustment of channel k while k is being written SHALL not alter latched data; dirty[k] set again so k is rewritten next.
REQ-016 Latency: dirty set in cycle n (FSM IDLE) -> dactrig high in cycle n+2.
REQ-017 With STEP >= 2^WIDTH, any more SHALL yield full scale and any less SHALL yield 0.

Reset
REQ-018 While RST high: lvl[i]=INIT, all dirty flags=1, state=IDLE, dactrig=0, busy=0, data=INIT, address=0, command=4'b0011, edge detectors cleared (input held high at release produces no edge).
REQ-019 RST asserted in TRIG or WAIT SHALL abort the write; after release all NCH channels are rewritten in order 0..NCH-1.

Verification
REQ-020 Reset release, driver returns dacdone 5 cycles after each dactrig -> four writes, address 0,1,2,3, data 12'h03F each, then busy=0.
REQ-021 chsel=2, more pulse x3 -> writes to address 2 with data 0x1CF, 0x35F, 0x4EF.
REQ-022 chsel=1, more held 20 cycles -> one write only, data 0x1CF; 11 more edges -> saturates 0xFFF, further edge still writes 0xFFF.
REQ-023 chsel=0, less edge from 0x03F -> data 0x000; less and more same cycle -> no write.
REQ-024 Channel 3 in WAIT, more edge on chsel=3 -> in-flight data unchanged, second write to address 3 with new value after dacdone.
REQ-025 RST pulsed during WAIT of address 1 -> dactrig stops, then channels 0..3 rewritten with 12'h03F.
